// File: rtl/jump_control_unit_if.sv
// Bundle between program memory output, the jump control unit and the sequencer.
// The jump control unit drives everything except the instruction word.
interface jump_control_unit_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       ir;
    logic             sync_reset;
    logic             jmp;
    logic             jmp_nz;
    logic             dont_jmp;
    logic [3:0]       jmp_addr;
    logic [CNT_W-1:0] loop_cnt;
    logic             running;

    modport master (
        input  ir,
        output sync_reset,
        output jmp,
        output jmp_nz,
        output dont_jmp,
        output jmp_addr,
        output loop_cnt,
        output running
    );

    modport slave (
        output ir,
        input  sync_reset,
        input  jmp,
        input  jmp_nz,
        input  dont_jmp,
        input  jmp_addr,
        input  loop_cnt,
        input  running
    );
endinterface

// File: rtl/jump_control_unit.sv
// Jump decode, hardware loop counter and reset stretcher in front of the
// 8-bit program sequencer.
module jump_control_unit #(
    parameter int CNT_W    = 4,
    parameter int RST_HOLD = 2
) (
    input  logic                clk,
    input  logic                sync_reset_n,
    jump_control_unit_if.master bus
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    localparam logic [0:0] ST_RESET = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [3:0] OP_LDC = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_JNZ = 4'hF;

    logic [0:0]       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0] loop_cnt;

    logic [3:0] opcode;
    logic       is_run;
    logic       is_jmp;
    logic       is_jnz;
    logic       is_ldc;
    logic       cnt_zero;

    // Decode is qualified by state only, so nothing here sees sync_reset_n.
    assign opcode   = bus.ir[7:4];
    assign is_run   = (state == ST_RUN);
    assign is_jmp   = is_run && (opcode == OP_JMP);
    assign is_jnz   = is_run && (opcode == OP_JNZ);
    assign is_ldc   = is_run && (opcode == OP_LDC);
    assign cnt_zero = (loop_cnt == '0);

    // NOTE: reset is tested inside the clocked block, so it only acts on an
    // edge; all state uses non-blocking assignments so every flop samples
    // pre-edge values.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state    <= ST_RESET;
            hold_cnt <= '0;
        end else if (state == ST_RESET) begin
            if (hold_cnt == HOLD_LAST) begin
                state <= ST_RUN;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    // Counter saturates at zero: an exhausted loop keeps falling through.
    always_ff @(posedge clk) begin
        if (!sync_reset_n || !is_run) begin
            loop_cnt <= '0;
        end else if (is_ldc) begin
            loop_cnt <= CNT_W'(bus.ir[3:0]);
        end else if (is_jnz && !cnt_zero) begin
            loop_cnt <= loop_cnt - CNT_W'(1);
        end
    end

    assign bus.sync_reset = !is_run;
    assign bus.running    = is_run;
    assign bus.jmp        = is_jmp;
    assign bus.jmp_nz     = is_jnz;
    assign bus.dont_jmp   = is_jnz && cnt_zero;
    assign bus.jmp_addr   = (is_jmp || is_jnz) ? bus.ir[3:0] : 4'h0;
    assign bus.loop_cnt   = loop_cnt;

    a_jump_exclusive : assert property (@(posedge clk) !(bus.jmp && bus.jmp_nz));
    a_dont_jmp_qual  : assert property (@(posedge clk) !bus.dont_jmp || bus.jmp_nz);
    a_reset_vs_run   : assert property (@(posedge clk) bus.sync_reset != bus.running);

endmodule

// File: tb/tb_jump_control_unit.sv
// Self-checking bench for jump_control_unit: directed scenarios plus random
// instruction streams compared against an integer-level reference model.
module tb_jump_control_unit;

    localparam int CNT_W    = 4;
    localparam int RST_HOLD = 2;
    localparam int VW       = 9 + CNT_W;

    logic       clk = 1'b0;
    logic       sync_reset_n;
    logic [7:0] ir;

    always #5 clk = ~clk;

    jump_control_unit_if #(.CNT_W(CNT_W)) bus ();
    assign bus.ir = ir;

    jump_control_unit #(
        .CNT_W   (CNT_W),
        .RST_HOLD(RST_HOLD)
    ) dut (
        .clk         (clk),
        .sync_reset_n(sync_reset_n),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: reset flag, edges since release, loop count as an int.
    bit m_in_reset;
    int m_edges;
    int m_cnt;

    function automatic logic [VW-1:0] dut_vec();
        return {bus.sync_reset, bus.running, bus.jmp, bus.jmp_nz, bus.dont_jmp,
                bus.jmp_addr, bus.loop_cnt};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic       j, jn, dj;
        logic [3:0] a;
        j = 1'b0; jn = 1'b0; dj = 1'b0; a = 4'h0;
        if (!m_in_reset) begin
            if (ir[7:4] == 4'hE) begin
                j = 1'b1; a = ir[3:0];
            end else if (ir[7:4] == 4'hF) begin
                jn = 1'b1; a = ir[3:0]; dj = (m_cnt == 0);
            end
        end
        return {m_in_reset, !m_in_reset, j, jn, dj, a, CNT_W'(m_cnt)};
    endfunction

    task automatic apply(input logic r, input logic [7:0] i);
        sync_reset_n = r;
        ir           = i;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!sync_reset_n) begin
            m_in_reset = 1'b1; m_edges = 0; m_cnt = 0;
        end else if (m_in_reset) begin
            m_edges++;
            if (m_edges >= RST_HOLD) m_in_reset = 1'b0;
        end else if (ir[7:4] == 4'hD) begin
            m_cnt = int'(ir[3:0]);
        end else if (ir[7:4] == 4'hF && m_cnt > 0) begin
            m_cnt--;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 8'hF3);
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, (k == 0) ? 8'hD7 : 8'hF3);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL reset_hold[%0d]: got %h expected %h", k, dut_vec(), exp_vec());
                n_fail++;
            end
            tick();
        end
        for (int k = 1; k <= RST_HOLD + 2; k++) begin
            apply(1'b1, 8'h00);
            n_checks++;
            if (bus.sync_reset !== (k - 1 < RST_HOLD) || bus.running !== !(k - 1 < RST_HOLD)
                || bus.loop_cnt !== '0) begin
                $display("FAIL reset_release[%0d]: got sync_reset=%b running=%b loop_cnt=%h expected sync_reset=%b",
                         k, bus.sync_reset, bus.running, bus.loop_cnt, (k - 1 < RST_HOLD));
                n_fail++;
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL reset_release_model[%0d]: got %h expected %h", k, dut_vec(), exp_vec());
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_jmp();
        apply(1'b1, 8'hD4);
        tick();
        apply(1'b1, 8'hE7);
        n_checks++;
        if (bus.jmp !== 1'b1 || bus.jmp_addr !== 4'h7 || bus.jmp_nz !== 1'b0 || bus.dont_jmp !== 1'b0) begin
            $display("FAIL jmp_decode: got jmp=%b addr=%h jmp_nz=%b dont_jmp=%b expected 1 7 0 0",
                     bus.jmp, bus.jmp_addr, bus.jmp_nz, bus.dont_jmp);
            n_fail++;
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL jmp_model: got %h expected %h", dut_vec(), exp_vec());
            n_fail++;
        end
        tick();
        apply(1'b1, 8'h00);
        n_checks++;
        if (bus.loop_cnt !== CNT_W'(4)) begin
            $display("FAIL jmp_keeps_cnt: got %h expected %h", bus.loop_cnt, CNT_W'(4));
            n_fail++;
        end
        tick();
    endtask

    task automatic test_loop();
        int exp_cnt[4] = '{3, 2, 1, 0};
        bit exp_dj[4]  = '{0, 0, 0, 1};
        apply(1'b1, 8'hD3);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'hF5);
            n_checks++;
            if (bus.loop_cnt !== CNT_W'(exp_cnt[i]) || bus.dont_jmp !== exp_dj[i]
                || bus.jmp_nz !== 1'b1 || bus.jmp_addr !== 4'h5) begin
                $display("FAIL loop[%0d]: got cnt=%h dont_jmp=%b jmp_nz=%b addr=%h expected cnt=%0d dont_jmp=%b jmp_nz=1 addr=5",
                         i, bus.loop_cnt, bus.dont_jmp, bus.jmp_nz, bus.jmp_addr, exp_cnt[i], exp_dj[i]);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_jnz_zero();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 8'hF2);
            n_checks++;
            if (bus.dont_jmp !== 1'b1 || bus.loop_cnt !== '0 || bus.jmp_addr !== 4'h2) begin
                $display("FAIL jnz_zero[%0d]: got dont_jmp=%b cnt=%h addr=%h expected 1 0 2",
                         i, bus.dont_jmp, bus.loop_cnt, bus.jmp_addr);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_loop();
        apply(1'b1, 8'hD9);
        tick();
        apply(1'b1, 8'hF1);
        tick();
        apply(1'b1, 8'hF1);
        tick();
        apply(1'b0, 8'hF1);
        n_checks++;
        if (bus.loop_cnt !== CNT_W'(7) || bus.jmp_nz !== 1'b1 || bus.sync_reset !== 1'b0) begin
            $display("FAIL mid_loop_pre: got cnt=%h jmp_nz=%b sync_reset=%b expected 7 1 0",
                     bus.loop_cnt, bus.jmp_nz, bus.sync_reset);
            n_fail++;
        end
        tick();
        apply(1'b0, 8'hF1);
        n_checks++;
        if (bus.loop_cnt !== '0 || bus.sync_reset !== 1'b1 || bus.jmp_nz !== 1'b0) begin
            $display("FAIL mid_loop_reset: got cnt=%h sync_reset=%b jmp_nz=%b expected 0 1 0",
                     bus.loop_cnt, bus.sync_reset, bus.jmp_nz);
            n_fail++;
        end
        tick();
        for (int i = 0; i < RST_HOLD; i++) begin
            apply(1'b1, 8'hF1);
            tick();
        end
        apply(1'b1, 8'hF1);
        n_checks++;
        if (bus.running !== 1'b1 || bus.dont_jmp !== 1'b1 || bus.loop_cnt !== '0) begin
            $display("FAIL mid_loop_after: got running=%b dont_jmp=%b cnt=%h expected 1 1 0",
                     bus.running, bus.dont_jmp, bus.loop_cnt);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_other_opcodes();
        logic [7:0] ops[3] = '{8'h00, 8'h5A, 8'hC3};
        apply(1'b1, 8'hD6);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, ops[i]);
            n_checks++;
            if ({bus.jmp, bus.jmp_nz, bus.dont_jmp, bus.jmp_addr} !== 7'b0 || bus.loop_cnt !== CNT_W'(6)) begin
                $display("FAIL other_op[%h]: got jmp=%b jmp_nz=%b dont_jmp=%b addr=%h cnt=%h expected 0 0 0 0 6",
                         ops[i], bus.jmp, bus.jmp_nz, bus.dont_jmp, bus.jmp_addr, bus.loop_cnt);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic       r;
        logic [7:0] i;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) != 0);
            case ($urandom_range(0, 3))
                0:       i = {4'hD, 4'($urandom_range(0, 15))};
                1:       i = {4'hE, 4'($urandom_range(0, 15))};
                2:       i = {4'hF, 4'($urandom_range(0, 15))};
                default: i = 8'($urandom);
            endcase
            apply(r, i);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL random[%0d] ir=%h rst_n=%b: got %h expected %h", n, i, r, dut_vec(), exp_vec());
                n_fail++;
            end
            tick();
        end
    endtask

    initial begin
        sync_reset_n = 1'b0;
        ir           = 8'h00;
        m_in_reset   = 1'b1;
        m_edges      = 0;
        m_cnt        = 0;
        test_reset();
        test_jmp();
        test_loop();
        test_jnz_zero();
        test_reset_mid_loop();
        test_other_opcodes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
